// File: rtl/pmem_responder_pkg.sv
// Shared types for the pmem responder: line type, offset width and FSM state encoding.
package pmem_responder_pkg;

    typedef logic [127:0] lc3b_line;

    localparam int PMEM_OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } pmem_state_t;

endpackage

// File: rtl/pmem_line_array.sv
// Single-port line RAM with registered read; contents survive reset.
module pmem_line_array
    import pmem_responder_pkg::*;
#(
    parameter int INDEX_BITS = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] index,
    input  lc3b_line              wdata,
    output lc3b_line              rdata
);

    lc3b_line mem [2**INDEX_BITS];

    // Read-first: rdata returns the old line on a write cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
        rdata <= mem[index];
    end

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency pmem responder: accepts one line read/write, pulses pmem_resp LATENCY cycles later.
module pmem_responder
    import pmem_responder_pkg::*;
#(
    parameter int LATENCY    = 8,
    parameter int INDEX_BITS = 12
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic         pmem_resp,
    output logic [127:0] pmem_rdata,
    output logic         busy,
    output logic         protocol_err
);

    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 2);

    pmem_state_t           state_q;
    logic [7:0]            cnt_q;
    logic                  op_wr_q;
    logic [INDEX_BITS-1:0] idx_q;
    lc3b_line              wdata_q;
    lc3b_line              rdata_q;
    logic                  resp_q;
    logic                  busy_q;
    logic                  err_q;

    logic                  req;
    logic [INDEX_BITS-1:0] live_idx;
    logic [INDEX_BITS-1:0] ram_index;
    logic                  ram_we;
    lc3b_line              ram_rdata;
    logic                  unused_addr_bits;

    assign req              = pmem_read | pmem_write;
    assign live_idx         = pmem_address[INDEX_BITS+PMEM_OFFSET_BITS-1:PMEM_OFFSET_BITS];
    assign unused_addr_bits = ^pmem_address;

    // The RAM sees the live index while idle so that the line is already being fetched
    // at the accept edge; this keeps the read correct even at the minimum latency of 2.
    assign ram_index = (state_q == IDLE) ? live_idx : idx_q;
    assign ram_we    = (state_q == RESP) && op_wr_q && reset_n;

    pmem_line_array #(
        .INDEX_BITS(INDEX_BITS)
    ) u_array (
        .clk  (clk),
        .we   (ram_we),
        .index(ram_index),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            resp_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q <= BUSY;
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                        op_wr_q <= pmem_write;
                        idx_q   <= live_idx;
                        wdata_q <= pmem_wdata;
                        if (pmem_read && pmem_write) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    // A requester that keeps asking must keep asking for the same thing.
                    if (req && ((pmem_write != op_wr_q) || (live_idx != idx_q))) begin
                        err_q <= 1'b1;
                    end
                    if (cnt_q == 8'd0) begin
                        state_q <= RESP;
                        resp_q  <= 1'b1;
                        if (!op_wr_q) begin
                            rdata_q <= ram_rdata;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    resp_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    resp_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_resp    = resp_q;
    assign pmem_rdata   = rdata_q;
    assign busy         = busy_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Randomized and directed bench for pmem_responder against a transaction-level memory model.
module tb_pmem_responder;

    localparam int LAT = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         pmem_read = 1'b0;
    logic         pmem_write = 1'b0;
    logic [15:0]  pmem_address = '0;
    logic [127:0] pmem_wdata = '0;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;
    logic         busy;
    logic         protocol_err;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    pmem_responder #(
        .LATENCY(LAT),
        .INDEX_BITS(12)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_address(pmem_address),
        .pmem_wdata  (pmem_wdata),
        .pmem_resp   (pmem_resp),
        .pmem_rdata  (pmem_rdata),
        .busy        (busy),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level model: one outstanding transaction, identified by its accept cycle.
    int           cyc = 0;
    bit           infl = 1'b0;
    int           resp_cyc = 0;
    bit           m_wr;
    int           m_idx;
    logic [127:0] m_wd;
    logic [127:0] m_rv;
    bit           rv_known;
    logic [127:0] m_rdata = '0;
    bit           rd_known = 1'b0;
    bit           m_err = 1'b0;
    logic [127:0] mm [int];

    always @(posedge clk) begin
        int  n;
        int  li;
        bit  lreq;
        cyc  = cyc + 1;
        n    = cyc;
        li   = int'(pmem_address[15:4]);
        lreq = pmem_read | pmem_write;
        if (!reset_n) begin
            infl     = 1'b0;
            m_err    = 1'b0;
            m_rdata  = '0;
            rd_known = 1'b1;
        end else if (infl) begin
            if (n - 1 == resp_cyc) begin
                if (m_wr) mm[m_idx] = m_wd;
                infl = 1'b0;
            end else begin
                if (lreq && ((bit'(pmem_write) != m_wr) || (li != m_idx))) m_err = 1'b1;
                if (n == resp_cyc && !m_wr) begin
                    m_rdata  = m_rv;
                    rd_known = rv_known;
                end
            end
        end else if (lreq) begin
            infl     = 1'b1;
            resp_cyc = n - 1 + LAT;
            m_wr     = pmem_write;
            m_idx    = li;
            m_wd     = pmem_wdata;
            if (pmem_read && pmem_write) m_err = 1'b1;
            rv_known = mm.exists(li);
            if (rv_known) m_rv = mm[li];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("resp", pmem_resp, infl && (cyc == resp_cyc));
            check("busy", busy, infl);
            check("protocol_err", protocol_err, m_err);
            if (rd_known) check("rdata", pmem_rdata, m_rdata);
        end
    end

    task automatic do_req(input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [127:0] wd, input int drop_after, input bit mutate,
                          output int t0, output int tr);
        @(negedge clk);
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wd;
        t0 = cyc;
        tr = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (pmem_resp) begin
                tr = cyc;
                break;
            end
            if (drop_after != 0 && k + 1 == drop_after) begin
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
            end
            if (mutate && k == 2) pmem_address = addr ^ 16'h0010;
        end
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        if (tr < 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got no pmem_resp within 100 cycles, required one");
        end
    endtask

    localparam logic [127:0] D_WR   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] LINE_A = 128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF;
    localparam logic [127:0] LINE_B = 128'hB0B1_B2B3_B4B5_B6B7_B8B9_BABB_BCBD_BEBF;
    localparam logic [127:0] FIVES  = {32{4'h5}};
    localparam logic [127:0] AS     = {32{4'hA}};
    localparam logic [127:0] ONES   = {128{1'b1}};

    initial begin
        int t0, tr, t1, tr1, nresp;
        logic [15:0] pool [8];
        int sel, kind, drop;
        bit rd, wr, mut;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en  = 1'b1;
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_resp", pmem_resp, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("idle_err", protocol_err, 1'b0);
        check("idle_rdata", pmem_rdata, 128'h0);

        do_req(0, 1, 16'h0080, LINE_A, 0, 0, t0, tr);
        do_req(0, 1, 16'h2000, LINE_B, 0, 0, t0, tr);
        do_req(0, 1, 16'h0300, FIVES, 0, 0, t0, tr);

        do_req(0, 1, 16'h1230, D_WR, 0, 0, t0, tr);
        check("wr_latency", 128'(tr - t0), 128'(8));
        do_req(1, 0, 16'h123C, '0, 0, 0, t0, tr);
        check("rd_latency", 128'(tr - t0), 128'(8));
        check("rd_after_wr", pmem_rdata, D_WR);

        do_req(0, 1, 16'h0040, 128'h1, 0, 0, t0, tr1);
        do_req(1, 0, 16'h0080, '0, 0, 0, t1, tr);
        check("b2b_spacing", 128'(tr - tr1), 128'(9));
        check("b2b_rdata", pmem_rdata, LINE_A);
        check("wr_keeps_rdata", pmem_rdata, LINE_A);

        do_req(1, 0, 16'h2000, '0, 3, 0, t0, tr);
        check("drop_latency", 128'(tr - t0), 128'(8));
        check("drop_err", protocol_err, 1'b0);
        check("drop_rdata", pmem_rdata, LINE_B);

        do_req(1, 1, 16'h0100, ONES, 0, 0, t0, tr);
        check("conflict_err", protocol_err, 1'b1);
        do_req(1, 0, 16'h0100, '0, 0, 0, t0, tr);
        check("conflict_rdata", pmem_rdata, ONES);
        check("conflict_err_sticky", protocol_err, 1'b1);

        @(negedge clk);
        pmem_write   = 1'b1;
        pmem_address = 16'h0300;
        pmem_wdata   = AS;
        repeat (3) @(negedge clk);
        reset_n    = 1'b0;
        pmem_write = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        nresp = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (pmem_resp) nresp++;
        end
        check("reset_abort_resp", 128'(nresp), 128'(0));
        check("reset_clears_err", protocol_err, 1'b0);
        do_req(1, 0, 16'h0300, '0, 0, 0, t0, tr);
        check("reset_no_commit", pmem_rdata, FIVES);

        for (int i = 0; i < 8; i++) begin
            pool[i] = 16'h0800 + 16'(i * 16'h0110);
            do_req(0, 1, pool[i] | 16'($urandom_range(0, 15)),
                   {$urandom, $urandom, $urandom, $urandom}, 0, 0, t0, tr);
        end
        for (int i = 0; i < 60; i++) begin
            sel  = $urandom_range(0, 7);
            kind = $urandom_range(0, 9);
            rd   = (kind < 5) || (kind == 9);
            wr   = (kind >= 5);
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            mut  = ($urandom_range(0, 7) == 0);
            do_req(rd, wr, pool[sel] | 16'($urandom_range(0, 15)),
                   {$urandom, $urandom, $urandom, $urandom}, drop, mut, t0, tr);
            if (tr >= 0) check("rand_latency", 128'(tr - t0), 128'(LAT));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running at 200000, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
